// File: rtl/decode_stage_hs_pkg.sv
// Shared constants for the decode stage: opcodes, ALU/CSR op encodings, default widths.
// The ALU-op mapping for arithmetic funct3 values is also kept here.
package decode_stage_hs_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned XADDR_DEF  = 5;
  localparam int unsigned ALUOPS_DEF = 4;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    SYSTEM_OP = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NEQ  = 4'd11,
    ALU_GE   = 4'd12,
    ALU_GEU  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_e;

  // alt = funct7 is 0100000; SUB only exists for register-register ops
  function automatic alu_op_e alu_arith(input logic [2:0] f3, input logic alt,
                                        input logic is_reg);
    case (f3)
      3'b000:  alu_arith = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_arith = ALU_SLL;
      3'b010:  alu_arith = ALU_SLT;
      3'b011:  alu_arith = ALU_SLTU;
      3'b100:  alu_arith = ALU_XOR;
      3'b101:  alu_arith = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_hs_if.sv
// Fetch, write-back, execute-hazard and output-bundle signals of the decode stage.
interface decode_stage_hs_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned XADDR  = 5,
  parameter int unsigned ALUOPS = 4
);
  logic              i_valid;
  logic              o_ready;
  logic [XLEN-1:0]   i_inst;
  logic [XLEN-1:0]   i_pc;
  logic              i_flush;
  logic              i_wr_en;
  logic [XADDR-1:0]  i_rd_addr;
  logic [XLEN-1:0]   i_rd_data;
  logic              i_ex_load;
  logic [XADDR-1:0]  i_ex_rd_addr;
  logic              or_valid;
  logic              i_ready;
  logic [6:0]        or_opcode;
  logic [2:0]        or_funct3;
  logic [6:0]        or_funct7;
  logic [XADDR-1:0]  or_rd_addr;
  logic [XADDR-1:0]  or_rs1_addr;
  logic [XADDR-1:0]  or_rs2_addr;
  logic [XLEN-1:0]   or_rs1_data;
  logic [XLEN-1:0]   or_rs2_data;
  logic [XLEN-1:0]   or_imm;
  logic [XLEN-1:0]   or_pc;
  logic [ALUOPS-1:0] or_alu_op;
  logic [11:0]       or_csr_addr;
  logic [1:0]        or_csr_op;
  logic              or_csr_imm;
  logic              or_illegal;

  modport slave (
    input  i_valid, i_inst, i_pc, i_flush, i_wr_en, i_rd_addr, i_rd_data,
           i_ex_load, i_ex_rd_addr, i_ready,
    output o_ready, or_valid, or_opcode, or_funct3, or_funct7, or_rd_addr,
           or_rs1_addr, or_rs2_addr, or_rs1_data, or_rs2_data, or_imm, or_pc,
           or_alu_op, or_csr_addr, or_csr_op, or_csr_imm, or_illegal
  );

  modport master (
    output i_valid, i_inst, i_pc, i_flush, i_wr_en, i_rd_addr, i_rd_data,
           i_ex_load, i_ex_rd_addr, i_ready,
    input  o_ready, or_valid, or_opcode, or_funct3, or_funct7, or_rd_addr,
           or_rs1_addr, or_rs2_addr, or_rs1_data, or_rs2_data, or_imm, or_pc,
           or_alu_op, or_csr_addr, or_csr_op, or_csr_imm, or_illegal
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Integer register file, two async read ports and one write port with write-to-read bypass.
// x0 is hard-wired to zero.
module regfile_2r1w #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned XADDR = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [XADDR-1:0] i_wr_addr,
  input  logic [XLEN-1:0]  i_wr_data,
  input  logic [XADDR-1:0] i_ra1,
  input  logic [XADDR-1:0] i_ra2,
  output logic [XLEN-1:0]  o_rd1,
  output logic [XLEN-1:0]  o_rd2
);
  localparam int unsigned NREGS = 1 << XADDR;

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NREGS; k++) mem[k] <= '0;
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != '0) o_rd1 = (i_wr_en && i_wr_addr == i_ra1) ? i_wr_data : mem[i_ra1];
    if (i_ra2 != '0) o_rd2 = (i_wr_en && i_wr_addr == i_ra2) ? i_wr_data : mem[i_ra2];
  end
endmodule

// File: rtl/decode_stage_hs.sv
// RV32I + Zicsr decode stage with valid/ready handshake, load-use interlock and flush.
// Holds the integer register file; output bundle is registered.
module decode_stage_hs
  import decode_stage_hs_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned XADDR  = XADDR_DEF,
  parameter int unsigned ALUOPS = ALUOPS_DEF
) (
  input logic               i_clk,
  input logic               i_rst,
  decode_stage_hs_if.slave  bus
);
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [XADDR-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic             f7_alt;
  logic             uses_rs2;
  logic             advance, hazard;

  alu_op_e          alu_d;
  csr_op_e          csr_op_d;
  logic             csr_imm_d;
  logic [11:0]      csr_addr_d;
  logic             illegal_d;
  logic [31:0]      imm32;

  assign opcode = bus.i_inst[6:0];
  assign f3     = bus.i_inst[14:12];
  assign f7     = bus.i_inst[31:25];
  assign rd     = bus.i_inst[11:7];
  assign rs1    = bus.i_inst[19:15];
  assign rs2    = bus.i_inst[24:20];
  assign f7_alt = (f7 == 7'b0100000);

  regfile_2r1w #(.XLEN(XLEN), .XADDR(XADDR)) u_rf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (bus.i_wr_en),
    .i_wr_addr (bus.i_rd_addr),
    .i_wr_data (bus.i_rd_data),
    .i_ra1     (rs1),
    .i_ra2     (rs2),
    .o_rd1     (rs1_data),
    .o_rd2     (rs2_data)
  );

  always_comb begin
    alu_d      = ALU_ADD;
    csr_op_d   = CSR_NONE;
    csr_imm_d  = 1'b0;
    csr_addr_d = '0;
    illegal_d  = 1'b0;
    imm32      = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: imm32 = {bus.i_inst[31:12], 12'b0};
      OP_JAL:   imm32 = {{12{bus.i_inst[31]}}, bus.i_inst[19:12], bus.i_inst[20],
                         bus.i_inst[30:21], 1'b0};
      OP_JALR, OP_LOAD: imm32 = {{20{bus.i_inst[31]}}, bus.i_inst[31:20]};
      OP_STORE: imm32 = {{20{bus.i_inst[31]}}, bus.i_inst[31:25], bus.i_inst[11:7]};
      OP_BRANCH: begin
        imm32 = {{20{bus.i_inst[31]}}, bus.i_inst[7], bus.i_inst[30:25],
                 bus.i_inst[11:8], 1'b0};
        case (f3)
          3'b000:  alu_d = ALU_EQ;
          3'b001:  alu_d = ALU_NEQ;
          3'b100:  alu_d = ALU_SLT;
          3'b101:  alu_d = ALU_GE;
          3'b110:  alu_d = ALU_SLTU;
          3'b111:  alu_d = ALU_GEU;
          default: illegal_d = 1'b1;
        endcase
      end
      OP_IMM: begin
        imm32 = {{20{bus.i_inst[31]}}, bus.i_inst[31:20]};
        alu_d = alu_arith(f3, f7_alt, 1'b0);
      end
      OP_OP: begin
        alu_d     = alu_arith(f3, f7_alt, 1'b1);
        illegal_d = !(f7_alt || f7 == 7'b0000000);
      end
      SYSTEM_OP: begin
        imm32      = {27'b0, bus.i_inst[19:15]};
        csr_addr_d = bus.i_inst[31:20];
        csr_op_d   = csr_op_e'(f3[1:0]);
        csr_imm_d  = f3[2];
        illegal_d  = (f3 == 3'b100);
      end
      default: illegal_d = 1'b1;
    endcase
  end

  assign uses_rs2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_OP);
  assign advance  = !bus.or_valid || bus.i_ready;
  // The load being tracked is the bundle now leaving decode, hence the or_valid term
  assign hazard   = bus.i_valid && bus.i_ex_load && bus.or_valid && (bus.i_ex_rd_addr != '0)
                    && ((bus.i_ex_rd_addr == rs1) || (uses_rs2 && bus.i_ex_rd_addr == rs2));
  assign bus.o_ready = advance && !hazard && !bus.i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.or_valid    <= 1'b0;
      bus.or_opcode   <= '0;
      bus.or_funct3   <= '0;
      bus.or_funct7   <= '0;
      bus.or_rd_addr  <= '0;
      bus.or_rs1_addr <= '0;
      bus.or_rs2_addr <= '0;
      bus.or_rs1_data <= '0;
      bus.or_rs2_data <= '0;
      bus.or_imm      <= '0;
      bus.or_pc       <= '0;
      bus.or_alu_op   <= '0;
      bus.or_csr_addr <= '0;
      bus.or_csr_op   <= '0;
      bus.or_csr_imm  <= 1'b0;
      bus.or_illegal  <= 1'b0;
    end else if (bus.i_flush) begin
      bus.or_valid <= 1'b0;
    end else if (advance) begin
      bus.or_valid <= bus.i_valid && bus.o_ready;
      if (bus.i_valid && bus.o_ready) begin
        bus.or_opcode   <= opcode;
        bus.or_funct3   <= f3;
        bus.or_funct7   <= f7;
        bus.or_rd_addr  <= rd;
        bus.or_rs1_addr <= rs1;
        bus.or_rs2_addr <= rs2;
        bus.or_rs1_data <= rs1_data;
        bus.or_rs2_data <= rs2_data;
        bus.or_imm      <= XLEN'($signed(imm32));
        bus.or_pc       <= bus.i_pc;
        bus.or_alu_op   <= ALUOPS'(alu_d);
        bus.or_csr_addr <= csr_addr_d;
        bus.or_csr_op   <= csr_op_d;
        bus.or_csr_imm  <= csr_imm_d;
        bus.or_illegal  <= illegal_d;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: decode fields, bypass, load-use bubble, stall, flush, reset.
module tb_decode_stage_hs;
  import decode_stage_hs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decode_stage_hs_if #(.XLEN(32), .XADDR(5), .ALUOPS(4)) bus ();

  decode_stage_hs #(.XLEN(32), .XADDR(5), .ALUOPS(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    bus.i_valid = 1'b1;
    bus.i_inst  = inst;
    bus.i_pc    = pc;
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_inst = '0; bus.i_pc = '0; bus.i_flush = 1'b0;
    bus.i_wr_en = 1'b0; bus.i_rd_addr = '0; bus.i_rd_data = '0;
    bus.i_ex_load = 1'b0; bus.i_ex_rd_addr = '0; bus.i_ready = 1'b1;

    step(); step();
    chk("rst_valid", 32'(bus.or_valid), 32'd0);
    chk("rst_imm", bus.or_imm, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);

    // addi x1,x0,5
    present(32'h00500093, 32'h100);
    step();
    chk("addi_valid", 32'(bus.or_valid), 32'd1);
    chk("addi_imm", bus.or_imm, 32'd5);
    chk("addi_alu", 32'(bus.or_alu_op), 32'(ALU_ADD));
    chk("addi_rd", 32'(bus.or_rd_addr), 32'd1);
    chk("addi_ill", 32'(bus.or_illegal), 32'd0);
    chk("addi_pc", bus.or_pc, 32'h100);

    present(32'h402081B3, 32'h104); // sub x3,x1,x2
    step();
    chk("sub_alu", 32'(bus.or_alu_op), 32'(ALU_SUB));
    chk("sub_rs2", 32'(bus.or_rs2_addr), 32'd2);
    chk("sub_imm", bus.or_imm, 32'd0);

    present(32'h4030D093, 32'h108); // srai x1,x1,3
    step();
    chk("srai_alu", 32'(bus.or_alu_op), 32'(ALU_SRA));
    chk("srai_sh", 32'(bus.or_imm[4:0]), 32'd3);
    chk("srai_ill", 32'(bus.or_illegal), 32'd0);

    present(32'h300110F3, 32'h10C); // csrrw x1,0x300,x2
    step();
    chk("csr_addr", 32'(bus.or_csr_addr), 32'h300);
    chk("csr_op", 32'(bus.or_csr_op), 32'd1);
    chk("csr_imm", 32'(bus.or_csr_imm), 32'd0);
    chk("csr_zimm", bus.or_imm, 32'd2);
    chk("csr_ill", 32'(bus.or_illegal), 32'd0);

    present(32'h00000000, 32'h110);
    step();
    chk("zero_ill", 32'(bus.or_illegal), 32'd1);
    chk("zero_valid", 32'(bus.or_valid), 32'd1);

    present(32'h00002063, 32'h114); // branch funct3=010
    step();
    chk("br010_ill", 32'(bus.or_illegal), 32'd1);

    present(32'h00209463, 32'h118); // bne x1,x2,+8
    step();
    chk("bne_alu", 32'(bus.or_alu_op), 32'(ALU_NEQ));
    chk("bne_imm", bus.or_imm, 32'd8);

    present(32'hFE20AE23, 32'h11C); // sw x2,-4(x1)
    step();
    chk("sw_imm", bus.or_imm, 32'hFFFFFFFC);

    present(32'h123450B7, 32'h120); // lui x1,0x12345
    step();
    chk("lui_imm", bus.or_imm, 32'h12345000);

    // write-back bypass into rs2
    present(32'h402081B3, 32'h124);
    bus.i_wr_en = 1'b1; bus.i_rd_addr = 5'd2; bus.i_rd_data = 32'hDEADBEEF;
    step();
    chk("byp_rs2", bus.or_rs2_data, 32'hDEADBEEF);
    present(32'h00028333, 32'h128); // add x6,x5,x0 while writing x0
    bus.i_rd_addr = 5'd0; bus.i_rd_data = 32'h12345678;
    step();
    chk("byp_x0", bus.or_rs2_data, 32'd0);
    bus.i_wr_en = 1'b0;
    present(32'h402081B3, 32'h12C);
    step();
    chk("rf_x2", bus.or_rs2_data, 32'hDEADBEEF);

    // load-use: lw x5,0(x1) then add x6,x5,x0
    present(32'h0000A283, 32'h130);
    step();
    chk("lw_valid", 32'(bus.or_valid), 32'd1);
    chk("lw_rd", 32'(bus.or_rd_addr), 32'd5);
    present(32'h00028333, 32'h134);
    bus.i_ex_load = 1'b1; bus.i_ex_rd_addr = 5'd5;
    #1;
    chk("lu_stall", 32'(bus.o_ready), 32'd0);
    step();
    chk("lu_bubble", 32'(bus.or_valid), 32'd0);
    chk("lu_ready", 32'(bus.o_ready), 32'd1);
    step();
    chk("lu_issue", 32'(bus.or_valid), 32'd1);
    chk("lu_rd", 32'(bus.or_rd_addr), 32'd6);
    bus.i_ex_load = 1'b0;

    // back-pressure for 3 cycles, then flush while write-back commits x7
    present(32'h4030D093, 32'h138);
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", 32'(bus.or_valid), 32'd1);
      chk("hold_rd", 32'(bus.or_rd_addr), 32'd6);
      chk("hold_pc", bus.or_pc, 32'h134);
    end
    bus.i_flush = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_rd_addr = 5'd7; bus.i_rd_data = 32'hA5A5A5A5;
    #1;
    chk("fl_ready", 32'(bus.o_ready), 32'd0);
    step();
    chk("fl_valid", 32'(bus.or_valid), 32'd0);
    bus.i_flush = 1'b0; bus.i_wr_en = 1'b0; bus.i_ready = 1'b1;
    present(32'h00038013, 32'h13C); // addi x0,x7,0
    step();
    chk("fl_wr", bus.or_rs1_data, 32'hA5A5A5A5);
    chk("fl_after", 32'(bus.or_valid), 32'd1);

    // asynchronous reset mid-stream
    present(32'h00500093, 32'h140);
    step();
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.or_valid), 32'd0);
    chk("arst_imm", bus.or_imm, 32'd0);
    chk("arst_rd", 32'(bus.or_rd_addr), 32'd0);
    chk("arst_pc", bus.or_pc, 32'd0);
    step();
    rst = 1'b0;
    present(32'h402081B3, 32'h144);
    step();
    chk("arst_rf", bus.or_rs2_data, 32'd0);
    bus.i_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
